// File: rtl/counter_capture_compare.sv
// counter_capture_compare
// Consumes the upstream free-running count: tracks count wraps, timestamps
// synchronised event edges into a 2-entry show-ahead FIFO, and pulses
// cmp_hit when the count first reaches a programmed compare value.
module counter_capture_compare #(
    parameter int CNT_W = 4,
    parameter int OVF_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   evt_in,
    output logic [OVF_W+CNT_W-1:0] cap_data,
    output logic                   cap_valid,
    input  logic                   cap_ready,
    output logic                   overrun,
    input  logic                   clr_overrun,
    input  logic [CNT_W-1:0]       cmp_val,
    input  logic                   cmp_en,
    output logic                   cmp_hit,
    output logic [OVF_W-1:0]       wrap_cnt
);

    localparam int TS_W  = OVF_W + CNT_W;
    localparam int DEPTH = 2;

    logic [CNT_W-1:0] prev_cnt_q;
    logic [OVF_W-1:0] wrap_cnt_q;
    logic             s1_q, s2_q, s3_q;
    logic             cmp_hit_q;
    logic             overrun_q, overrun_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [0:0]       wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;

    logic             wrap_now;
    logic             rise;
    logic             full, empty;
    logic             push, pop;
    logic [TS_W-1:0]  ts;

    // Only the exact all-ones -> zero step counts as a wrap; other jumps are ignored.
    assign wrap_now = (prev_cnt_q == {CNT_W{1'b1}}) && (cnt_in == '0);
    assign rise     = s2_q & ~s3_q;
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign pop      = ~empty & cap_ready;
    assign push     = rise & (~full | pop);
    // Adding wrap_now keeps the timestamp coherent when the capture lands on the wrap cycle.
    assign ts       = {wrap_cnt_q + OVF_W'(wrap_now), cnt_in};

    assign cap_valid = ~empty;
    assign cap_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign overrun   = overrun_q;
    assign cmp_hit   = cmp_hit_q;
    assign wrap_cnt  = wrap_cnt_q;

    // Sample the count history, wrap counter and event synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cnt_q <= '0;
            wrap_cnt_q <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
        end else begin
            prev_cnt_q <= cnt_in;
            wrap_cnt_q <= wrap_cnt_q + OVF_W'(wrap_now);
            s1_q       <= evt_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
        end
    end

    // Compare pulse fires only on the cycle the count first arrives at cmp_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_hit_q <= 1'b0;
        end else begin
            cmp_hit_q <= cmp_en && (cnt_in == cmp_val) && (prev_cnt_q != cmp_val);
        end
    end

    // Occupancy and sticky overrun next-state; an overrun set beats a same-cycle clear.
    always_comb begin
        count_d   = count_q;
        overrun_d = overrun_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (rise && full && !pop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO pointers, occupancy and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Per-entry timestamp storage; contents are don't-care while the entry is unused.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == 1'(gi))) begin
                    mem_q[gi] <= ts;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_counter_capture_compare.sv
// Directed bench for counter_capture_compare: reset, wrap counting, event
// capture (normal and on the wrap cycle), FIFO full/overrun, full push+pop,
// and compare pulses. Outputs are sampled 1 time unit after each rising edge.
module tb_counter_capture_compare;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       evt_in;
    logic [7:0] cap_data;
    logic       cap_valid;
    logic       cap_ready;
    logic       overrun;
    logic       clr_overrun;
    logic [3:0] cmp_val;
    logic       cmp_en;
    logic       cmp_hit;
    logic [3:0] wrap_cnt;

    int checks = 0;
    int errors = 0;
    bit free_run = 0;

    counter_capture_compare #(.CNT_W(4), .OVF_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .evt_in      (evt_in),
        .cap_data    (cap_data),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .cmp_val     (cmp_val),
        .cmp_en      (cmp_en),
        .cmp_hit     (cmp_hit),
        .wrap_cnt    (wrap_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One clock: wait for the edge, step past it, then advance the upstream count.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (free_run) cnt_in = cnt_in + 4'd1;
    endtask

    // Idle low for 3 cycles, then a 2-cycle event with the count frozen at c.
    // The entry is written at the third edge, so it is visible on return.
    task automatic pulse_evt(input logic [3:0] c);
        evt_in = 1'b0;
        repeat (3) cyc();
        cnt_in = c;
        evt_in = 1'b1;
        cyc();
        cyc();
        evt_in = 1'b0;
        cyc();
    endtask

    int hits;
    logic [3:0] c;

    initial begin
        rst = 1'b1; cnt_in = 4'd0; evt_in = 1'b0; cap_ready = 1'b0;
        clr_overrun = 1'b0; cmp_val = 4'd0; cmp_en = 1'b0;
        free_run = 1;

        // Reset with counting input: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_wrap",  wrap_cnt,  0);
            check("rst_valid", cap_valid, 0);
            check("rst_data",  cap_data,  0);
            check("rst_ovr",   overrun,   0);
            check("rst_hit",   cmp_hit,   0);
        end
        rst = 1'b0;                          // cnt_in = 3 now

        // Samples 3..15: no wrap yet.
        repeat (13) cyc();
        check("wrap_pre", wrap_cnt, 0);
        cyc();                               // samples 0 after 15
        check("wrap_1", wrap_cnt, 1);
        repeat (15) cyc();
        check("wrap_1_hold", wrap_cnt, 1);
        cyc();
        check("wrap_2", wrap_cnt, 2);

        // Single capture: evt rises while cnt_in=5, wrap_cnt=3 -> {3,7}.
        repeat (20) cyc();                   // cnt_in = 5
        check("wrap_3", wrap_cnt, 3);
        evt_in = 1'b1; cap_ready = 1'b1;
        cyc(); check("cap1_lat0", cap_valid, 0);
        cyc(); check("cap1_lat1", cap_valid, 0);
        cyc(); check("cap1_valid", cap_valid, 1);
               check("cap1_data",  cap_data,  8'h37);
        cyc(); check("cap1_popped", cap_valid, 0);
        cyc(); check("cap1_level_once", cap_valid, 0);
        evt_in = 1'b0;                       // cnt_in = 10

        // Wrap-cycle capture: rise cycle has prev=15, cnt_in=0 -> {4,0}.
        repeat (4) cyc();                    // cnt_in = 14
        check("wcap_wrap_pre", wrap_cnt, 3);
        evt_in = 1'b1;
        cyc(); cyc();
        cyc(); check("wcap_valid", cap_valid, 1);
               check("wcap_data",  cap_data,  8'h40);
               check("wcap_wrap",  wrap_cnt,  4);
        cyc(); check("wcap_popped", cap_valid, 0);

        // FIFO full / overrun with consumer stalled.
        free_run = 0; cap_ready = 1'b0;
        pulse_evt(4'd2);
        check("ovr_a_valid", cap_valid, 1);
        check("ovr_a_data",  cap_data,  8'h42);
        pulse_evt(4'd5);
        check("ovr_b_noovr", overrun,  0);
        pulse_evt(4'd9);
        check("ovr_set",       overrun,  1);
        check("ovr_head_kept", cap_data, 8'h42);
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        check("ovr_clear", overrun, 0);
        cap_ready = 1'b1;
        cyc(); check("ovr_pop1_data",  cap_data,  8'h45);
               check("ovr_pop1_valid", cap_valid, 1);
        cyc(); check("ovr_pop2_valid", cap_valid, 0);
               check("ovr_pop2_data",  cap_data,  0);
        cap_ready = 1'b0;

        // Full FIFO with push and pop in the same cycle.
        pulse_evt(4'd3);
        pulse_evt(4'd6);
        check("pp_head_a", cap_data, 8'h43);
        evt_in = 1'b0;
        repeat (3) cyc();
        cnt_in = 4'd12; evt_in = 1'b1;
        cyc(); cyc();                        // now in the rise cycle, FIFO full
        cap_ready = 1'b1;
        cyc();
        cap_ready = 1'b0; evt_in = 1'b0;
        check("pp_head_b", cap_data,  8'h46);
        check("pp_valid",  cap_valid, 1);
        check("pp_noovr",  overrun,   0);
        cyc(); cyc();
        check("pp_hold_b", cap_data, 8'h46);
        cap_ready = 1'b1;
        cyc(); check("pp_head_c", cap_data,  8'h4c);
        cyc(); check("pp_empty",  cap_valid, 0);
        cap_ready = 1'b0;

        // Compare on a free-running count: one pulse per pass, right after 9.
        cmp_val = 4'd9; cmp_en = 1'b1; free_run = 1;
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            c = cnt_in;
            cyc();
            check($sformatf("cmp_run_%0d", c), cmp_hit, (c == 4'd9));
            if (cmp_hit) hits++;
        end
        check("cmp_run_pulses", hits, 2);

        // Count stalled at 9 for 5 cycles: a single pulse.
        free_run = 0;
        cnt_in = 4'd8;
        cyc(); check("stall_pre", cmp_hit, 0);
        cnt_in = 4'd9;
        cyc(); check("stall_first", cmp_hit, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); check("stall_held", cmp_hit, 0);
        end
        cnt_in = 4'd10;
        cyc(); check("stall_leave", cmp_hit, 0);

        // Compare disabled: no pulses.
        cmp_en = 1'b0; free_run = 1;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (cmp_hit) hits++;
        end
        check("cmp_dis_pulses", hits, 0);

        // cmp_val = 0 matches on the wrap: exactly one pulse per 16 counts.
        cmp_en = 1'b1; cmp_val = 4'd0;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (cmp_hit) hits++;
        end
        check("cmp_zero_pulses", hits, 1);
        cmp_en = 1'b0;

        // Reset mid-operation discards buffered entries.
        free_run = 0;
        pulse_evt(4'd1);
        check("mrst_pre_valid", cap_valid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_valid", cap_valid, 0);
        check("mrst_data",  cap_data,  0);
        check("mrst_wrap",  wrap_cnt,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
